// File: rtl/phys_reg_free_list_pkg.sv
// Shared core package for the rename machinery.
//
// Holds the physical-tag type and the default register-file sizes. The
// register map table and the instruction queue import this package as well,
// so every block agrees on the tag width.
//
// Contents:
//   PHYS_REGS_DEFAULT - number of physical registers (power of two)
//   ARCH_REGS_DEFAULT - number of architectural registers, all mapped at reset
//   PHYS_TAG_W        - width of a physical register tag
//   phys_tag_t        - physical register tag type
package phys_reg_free_list_pkg;

  localparam int PHYS_REGS_DEFAULT = 64;
  localparam int ARCH_REGS_DEFAULT = 32;
  localparam int PHYS_TAG_W        = $clog2(PHYS_REGS_DEFAULT);

  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;

endpackage

// File: rtl/free_list_fifo.sv
// Circular FIFO storage and pointer arithmetic for the physical register
// free list.
//
// Three pointers walk the ring. The alloc head marks the next tag to hand
// out. The commit head trails it and marks the oldest allocation that has not
// yet retired. The tail marks where released tags are written. Entries from
// the commit head up to the alloc head are allocated but still speculative.
// A restore rewinds the alloc head to the commit head, which returns those
// entries to the list in their original order.
//
// Optional build macro: FREE_LIST_CHECK_EN adds the commit_tag output, which
// the checker uses to track speculative tags.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   pop              - advance the alloc head (a grant happened)
//   push, push_tag   - write push_tag at the tail and advance the tail
//   commit           - advance the commit head
//   restore          - rewind the alloc head to the next commit head
//   head_tag         - entry at the alloc head
//   commit_tag       - entry at the commit head (FREE_LIST_CHECK_EN only)
//   tail_next        - tail pointer after this cycle's push
//   commit_next      - commit head after this cycle's commit
//   outstanding_none - alloc head equals commit head (nothing speculative)
module free_list_fifo
  import phys_reg_free_list_pkg::*;
#(
  parameter int PHYS_REGS = PHYS_REGS_DEFAULT,
  parameter int ARCH_REGS = ARCH_REGS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pop,
  input  logic                         push,
  input  logic [$clog2(PHYS_REGS)-1:0] push_tag,
  input  logic                         commit,
  input  logic                         restore,
  output logic [$clog2(PHYS_REGS)-1:0] head_tag,
`ifdef FREE_LIST_CHECK_EN
  output logic [$clog2(PHYS_REGS)-1:0] commit_tag,
`endif
  output logic [$clog2(PHYS_REGS)-1:0] tail_next,
  output logic [$clog2(PHYS_REGS)-1:0] commit_next,
  output logic                         outstanding_none
);

  localparam int PTR_W     = $clog2(PHYS_REGS);
  localparam int INIT_FREE = PHYS_REGS - ARCH_REGS;

  logic [PTR_W-1:0] mem [PHYS_REGS];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] commit_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] head_d;

  // Pointer arithmetic. PHYS_REGS is a power of two, so the pointers wrap
  // naturally at PTR_W bits.
  always_comb begin
    commit_next = commit_q + PTR_W'(commit);
    tail_next   = tail_q + PTR_W'(push);
    head_d      = restore ? commit_next : head_q + PTR_W'(pop);
  end

  assign head_tag         = mem[head_q];
  assign outstanding_none = (head_q == commit_q);
`ifdef FREE_LIST_CHECK_EN
  assign commit_tag = mem[commit_q];
`endif

  // Tag storage. At reset the first INIT_FREE slots hold the tags that no
  // architectural register maps to; the remaining slots are unused until
  // tags are released into them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        mem[i] <= (i < INIT_FREE) ? PTR_W'(ARCH_REGS + i) : '0;
      end
    end else if (push) begin
      mem[tail_q] <= push_tag;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= PTR_W'(INIT_FREE);
    end else begin
      head_q   <= head_d;
      commit_q <= commit_next;
      tail_q   <= tail_next;
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list for the rename stage.
//
// Hands out one free physical tag per cycle. Tags released by retiring
// instructions are queued for reuse. Speculative allocations stay
// recoverable until they commit, and a flush returns every uncommitted
// allocation to the list. Tag 0 backs $zero, so it is never renamed and
// releases of it are ignored.
//
// Optional build macro: FREE_LIST_CHECK_EN adds a per-tag free vector and a
// sticky err output. err flags a double free, a grant of a tag that is not
// free, or a commit with nothing outstanding.
//
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset
//   alloc_req    - rename requests one tag this cycle
//   alloc_gnt    - tag granted (allocation consumed this cycle)
//   alloc_tag    - granted tag, valid while alloc_gnt=1
//   free_valid   - retiring instruction releases free_tag
//   free_tag     - tag being released
//   commit_alloc - oldest outstanding allocation becomes permanent
//   flush        - squash: uncommitted allocations return to the list
//   free_count   - number of tags available
//   empty        - free_count == 0
//   err          - sticky consistency error (FREE_LIST_CHECK_EN only)
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  parameter int PHYS_REGS = PHYS_REGS_DEFAULT,
  parameter int ARCH_REGS = ARCH_REGS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_req,
  output logic                         alloc_gnt,
  output logic [$clog2(PHYS_REGS)-1:0] alloc_tag,
  input  logic                         free_valid,
  input  logic [$clog2(PHYS_REGS)-1:0] free_tag,
  input  logic                         commit_alloc,
  input  logic                         flush,
  output logic [$clog2(PHYS_REGS):0]   free_count,
  output logic                         empty
`ifdef FREE_LIST_CHECK_EN
  ,
  output logic                         err
`endif
);

  localparam int PTR_W = $clog2(PHYS_REGS);

  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             free_acc;
  logic             commit_acc;
  logic             outstanding_none;
  logic [PTR_W-1:0] head_tag;
  logic [PTR_W-1:0] tail_next;
  logic [PTR_W-1:0] commit_next;
`ifdef FREE_LIST_CHECK_EN
  logic [PTR_W-1:0] commit_tag;
`endif

  // Grant uses only registered state, so a tag released this cycle cannot
  // be handed out until the next one. The reset term keeps the grant low
  // while the registers still hold pre-reset contents.
  assign empty      = (count_q == '0);
  assign alloc_gnt  = alloc_req & ~empty & ~flush & ~rst;
  assign alloc_tag  = head_tag;
  assign free_count = count_q;

  // Releasing tag 0 is a no-op. A commit with no speculative allocation
  // outstanding has nothing to make permanent, so it is dropped.
  assign free_acc   = free_valid & (free_tag != '0);
  assign commit_acc = commit_alloc & ~outstanding_none;

  free_list_fifo #(
    .PHYS_REGS(PHYS_REGS),
    .ARCH_REGS(ARCH_REGS)
  ) u_fifo (
    .clk             (clk),
    .rst             (rst),
    .pop             (alloc_gnt),
    .push            (free_acc),
    .push_tag        (free_tag),
    .commit          (commit_acc),
    .restore         (flush),
    .head_tag        (head_tag),
`ifdef FREE_LIST_CHECK_EN
    .commit_tag      (commit_tag),
`endif
    .tail_next       (tail_next),
    .commit_next     (commit_next),
    .outstanding_none(outstanding_none)
  );

  // On a flush the free region becomes everything from the new commit head
  // up to the new tail. The distance cannot reach PHYS_REGS because tag 0
  // never sits in the ring, so a modulo-PHYS_REGS difference is exact.
  // Otherwise the count just tracks grants and accepted releases.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = {1'b0, tail_next - commit_next};
    end else begin
      count_d = count_q - (PTR_W + 1)'(alloc_gnt) + (PTR_W + 1)'(free_acc);
    end
  end

  // Free-count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= (PTR_W + 1)'(PHYS_REGS - ARCH_REGS);
    end else begin
      count_q <= count_d;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [PHYS_REGS-1:0] free_vec_q;
  logic [PHYS_REGS-1:0] free_vec_d;
  logic [PHYS_REGS-1:0] spec_q;
  logic [PHYS_REGS-1:0] spec_d;
  logic                 err_d;

  // free_vec marks tags currently available. spec marks tags granted but not
  // yet committed, so a flush can mark them free again without scanning the
  // ring. The commit head entry is the allocation a commit retires.
  always_comb begin
    free_vec_d = free_vec_q;
    spec_d     = spec_q;
    if (commit_acc) begin
      spec_d[commit_tag] = 1'b0;
    end
    if (alloc_gnt) begin
      free_vec_d[alloc_tag] = 1'b0;
      spec_d[alloc_tag]     = 1'b1;
    end
    if (flush) begin
      free_vec_d = free_vec_d | spec_d;
      spec_d     = '0;
    end
    if (free_acc) begin
      free_vec_d[free_tag] = 1'b1;
    end
    err_d = err
          | (free_acc & free_vec_q[free_tag])
          | (alloc_gnt & ~free_vec_q[alloc_tag])
          | (commit_alloc & outstanding_none);
  end

  // Checker registers. Tags at or above ARCH_REGS start out free.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        free_vec_q[i] <= (i >= ARCH_REGS);
      end
      spec_q <= '0;
      err    <= 1'b0;
    end else begin
      free_vec_q <= free_vec_d;
      spec_q     <= spec_d;
      err        <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list.
//
// A queue-based reference model (free list, speculative allocations, and a
// pool of committed tags that may later be released) produces the expected
// grant, tag and count for every cycle. Expectations are pushed to a
// scoreboard when stimulus is driven and popped when outputs are sampled.
// A table of hand-computed vectors covers the commit/flush corner cases.
// With FREE_LIST_CHECK_EN defined, the err output is also checked.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      alloc_req = 1'b0;
  logic      alloc_gnt;
  phys_tag_t alloc_tag;
  logic      free_valid = 1'b0;
  phys_tag_t free_tag = '0;
  logic      commit_alloc = 1'b0;
  logic      flush = 1'b0;
  logic [6:0] free_count;
  logic      empty;
`ifdef FREE_LIST_CHECK_EN
  logic      err;
`endif

  typedef struct {
    bit    gnt;
    int    tag;
    int    count;
    string name;
  } exp_t;

  typedef struct {
    bit req;
    bit fv;
    int ftag;
    bit cm;
    bit fl;
    bit gnt;
    int tag;
    int count;
  } vec_t;

  exp_t sb_q[$];
  int   free_q[$];
  int   spec_q[$];
  int   pool_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_tag;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_req   (alloc_req),
    .alloc_gnt   (alloc_gnt),
    .alloc_tag   (alloc_tag),
    .free_valid  (free_valid),
    .free_tag    (free_tag),
    .commit_alloc(commit_alloc),
    .flush       (flush),
    .free_count  (free_count),
    .empty       (empty)
`ifdef FREE_LIST_CHECK_EN
    ,
    .err         (err)
`endif
  );

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit isOutstanding(input int t);
    foreach (spec_q[i]) if (spec_q[i] == t) return 1'b1;
    foreach (pool_q[i]) if (pool_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    free_q = {};
    spec_q = {};
    pool_q = {};
    for (int t = 32; t < 64; t++) free_q.push_back(t);
    for (int t = 1; t < 32; t++) pool_q.push_back(t);
  endtask

  // Pops the oldest expectation and compares it with the DUT outputs.
  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checkValue("scoreboard underflow", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    checkValue({e.name, " gnt"}, 32'(alloc_gnt), 32'(e.gnt));
    if (e.gnt) checkValue({e.name, " tag"}, 32'(alloc_tag), e.tag);
    checkValue({e.name, " count"}, 32'(free_count), e.count);
    checkValue({e.name, " empty"}, 32'(empty), 32'(e.count == 0));
  endtask

  // Drives one cycle, pushes the expectation (from the model or from a
  // table row), samples the outputs, then advances the model.
  task automatic applyStimulus(input string label, input bit req, input bit fv, input int ftag,
                               input bit cm, input bit fl, input bit use_row = 1'b0,
                               input bit rg = 1'b0, input int rtag = 0, input int rcount = 0);
    exp_t e;
    bit   g;
    @(negedge clk);
    rst          = 1'b0;
    alloc_req    = req;
    free_valid   = fv;
    free_tag     = phys_tag_t'(ftag);
    commit_alloc = cm;
    flush        = fl;
    g      = req && (free_q.size() > 0) && !fl;
    e.name = label;
    if (use_row) begin
      e.gnt   = rg;
      e.tag   = rtag;
      e.count = rcount;
    end else begin
      e.gnt   = g;
      e.tag   = g ? free_q[0] : 0;
      e.count = free_q.size();
    end
    sb_q.push_back(e);
    #1;
    if (alloc_gnt === 1'b1) begin
      last_tag = int'(alloc_tag);
      checkValue({label, " dup"}, 32'(isOutstanding(int'(alloc_tag))), 0);
    end
    checkOutput();
    if (cm && spec_q.size() > 0) pool_q.push_back(spec_q.pop_front());
    if (fl) begin
      while (spec_q.size() > 0) free_q.push_front(spec_q.pop_back());
    end else if (g) begin
      spec_q.push_back(free_q.pop_front());
    end
    if (fv && ftag != 0) begin
      foreach (pool_q[i]) begin
        if (pool_q[i] == ftag) begin
          pool_q.delete(i);
          break;
        end
      end
      free_q.push_back(ftag);
    end
  endtask

  // One reset cycle with pending traffic that must be discarded.
  task automatic resetDut();
    @(negedge clk);
    rst          = 1'b1;
    alloc_req    = 1'b1;
    free_valid   = 1'b1;
    free_tag     = phys_tag_t'(5);
    commit_alloc = 1'b1;
    flush        = 1'b0;
    #1;
    checkValue("reset gnt", 32'(alloc_gnt), 0);
    modelReset();
  endtask

`ifdef FREE_LIST_CHECK_EN
  task automatic checkErr(input string name, input bit expected);
    checkValue(name, 32'(err), 32'(expected));
  endtask
`endif

  initial begin
    vec_t vecs[13];
    int   req_i, cm_i, fv_i, ftag_i, fl_i;

    // 5 allocs, 2 commits, flush, then flush with commit and free of tag 7.
    vecs[0]  = '{1, 0, 0, 0, 0, 1, 32, 32};
    vecs[1]  = '{1, 0, 0, 0, 0, 1, 33, 31};
    vecs[2]  = '{1, 0, 0, 0, 0, 1, 34, 30};
    vecs[3]  = '{1, 0, 0, 0, 0, 1, 35, 29};
    vecs[4]  = '{1, 0, 0, 0, 0, 1, 36, 28};
    vecs[5]  = '{0, 0, 0, 1, 0, 0, 0, 27};
    vecs[6]  = '{0, 0, 0, 1, 0, 0, 0, 27};
    vecs[7]  = '{1, 0, 0, 0, 1, 0, 0, 27};
    vecs[8]  = '{1, 0, 0, 0, 0, 1, 34, 30};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 29};
    vecs[10] = '{1, 1, 7, 1, 1, 0, 0, 29};
    vecs[11] = '{1, 0, 0, 0, 0, 1, 35, 30};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 29};

    $display("[TB] start");

    // Drain the list: tags 32..63 in order, then nothing on the 33rd.
    resetDut();
    for (int i = 0; i < 32; i++) applyStimulus("drain", 1, 0, 0, 0, 0);
    applyStimulus("drain 33rd", 1, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 32; i++) applyStimulus("commit all", 0, 0, 0, 1, 0);

    // Empty list: same-cycle release of 40 is not bypassed.
    applyStimulus("empty free40", 1, 1, 40, 0, 0, 1'b1, 1'b0, 0, 0);
    applyStimulus("grant40", 1, 0, 0, 0, 0, 1'b1, 1'b1, 40, 1);
    applyStimulus("after40", 0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
`ifdef FREE_LIST_CHECK_EN
    checkErr("err drain", 1'b0);
`endif

    // Table-driven commit/flush vectors.
    resetDut();
    foreach (vecs[i]) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].req, vecs[i].fv, vecs[i].ftag,
                    vecs[i].cm, vecs[i].fl, 1'b1, vecs[i].gnt, vecs[i].tag, vecs[i].count);
    end
    // Tag 7 was queued behind 36..63 during the flush.
    for (int i = 0; i < 29; i++) applyStimulus("drain to 7", 1, 0, 0, 0, 0);
    checkValue("tag7 queued", 32'(last_tag), 7);
    applyStimulus("after 7", 1, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0);

    // Tag 0 release is ignored; stray commit is ignored.
    resetDut();
    applyStimulus("free0", 0, 1, 0, 0, 0);
    applyStimulus("after free0", 0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 32);
    applyStimulus("stray commit", 0, 0, 0, 1, 0);
    applyStimulus("alloc after commit", 1, 0, 0, 0, 0);
    applyStimulus("flush after commit", 0, 0, 0, 0, 1);
    applyStimulus("regrant32", 1, 0, 0, 0, 0, 1'b1, 1'b1, 32, 32);
`ifdef FREE_LIST_CHECK_EN
    checkErr("err stray commit", 1'b1);
    resetDut();
    applyStimulus("err idle", 0, 0, 0, 0, 0);
    checkErr("err after reset", 1'b0);
    applyStimulus("double free45", 0, 1, 45, 0, 0);
    applyStimulus("err idle2", 0, 0, 0, 0, 0);
    checkErr("err double free", 1'b1);
    applyStimulus("err idle3", 0, 0, 0, 0, 0);
    checkErr("err sticky", 1'b1);
`endif

    // Random wrap-around traffic.
    resetDut();
    for (int c = 0; c < 200; c++) begin
      req_i  = ($urandom_range(0, 9) < 6) ? 1 : 0;
      cm_i   = (spec_q.size() > 0 && $urandom_range(0, 9) < 6) ? 1 : 0;
      fv_i   = (pool_q.size() > 0 && $urandom_range(0, 9) < 5) ? 1 : 0;
      ftag_i = fv_i ? pool_q[$urandom_range(0, pool_q.size() - 1)] : 0;
      fl_i   = ($urandom_range(0, 19) == 0) ? 1 : 0;
      applyStimulus("random", req_i[0], fv_i[0], ftag_i, cm_i[0], fl_i[0]);
    end
`ifdef FREE_LIST_CHECK_EN
    checkErr("err random", 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

Interface
REQ-001 SHALL have parameter PHYS_REGS, default 64, number of physical registers; power of two.
REQ-002 SHALL have parameter ARCH_REGS, default 32, number of architectural registers, all mapped at reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous and active-high.
REQ-005 SHALL have port alloc_req  input  1  rename stage requests one free physical tag this cycle.
REQ-006 SHALL have port alloc_gnt  output  1  tag granted; allocation consumed this cycle.
REQ-007 SHALL have port alloc_tag  output  log2(PHYS_REGS)  granted tag; valid only while alloc_gnt=1.
REQ-008 SHALL have port free_valid  input  1  retiring instruction releases its old physical mapping.
REQ-009 SHALL have port free_tag  input  log2(PHYS_REGS)  tag being released.
REQ-010 SHALL have port commit_alloc  input  1  oldest allocating instruction retired; its allocation becomes permanent.
REQ-011 SHALL have port flush  input  1  pipeline squash; all uncommitted allocations return to the list.
REQ-012 SHALL have port free_count  output  log2(PHYS_REGS)+1  number of tags available.
REQ-013 SHALL have port empty  output  1  free_count==0.

Function
REQ-014 SHALL hold free tags in a circular FIFO of PHYS_REGS entries with alloc head, commit head, tail and count registers.
REQ-015 SHALL drive alloc_gnt = alloc_req & ~empty & ~flush, combinationally from registered state; alloc_tag = FIFO[head].
REQ-016 SHALL advance head by one (modulo PHYS_REGS) on each grant.
REQ-017 SHALL write free_tag at tail and advance tail on free_valid, except free_tag==0, which SHALL be ignored ($zero is never renamed).
REQ-018 SHALL advance commit head by one on commit_alloc; commit_alloc when commit head equals head SHALL be ignored.
REQ-019 SHALL, on flush, set head to commit head (after same-cycle commit_alloc) and set count = tail_next - commit_head_next modulo PHYS_REGS.
REQ-020 SHALL otherwise update count = count - alloc_gnt + accepted free.
REQ-021 SHALL not bypass: a tag freed in cycle N is grantable no earlier than cycle N+1; alloc and free on empty in the same cycle grant nothing and leave free_count=1.
REQ-022 SHALL apply free_valid in flush cycles normally.
REQ-023 SHALL wrap all pointers modulo PHYS_REGS; overflow is impossible because at most PHYS_REGS-1 tags exist outside $zero.

Reset
REQ-024 SHALL, while rst=1, load FIFO entries 0..PHYS_REGS-ARCH_REGS-1 with tags ARCH_REGS..PHYS_REGS-1, set head=commit head=0, tail=PHYS_REGS-ARCH_REGS, and count=PHYS_REGS-ARCH_REGS.
REQ-025 SHALL hold alloc_gnt=0 during reset; after reset free_count=32 and empty=0 (defaults).
REQ-026 SHALL let reset mid-operation discard all pending allocations, commits and frees in that cycle.

Configuration
REQ-027 SHALL, with FREE_LIST_CHECK_EN defined, keep a PHYS_REGS-bit free-tag vector and add output err (1 bit, sticky until reset), set on free of an already-free tag, alloc of a non-free tag, or commit_alloc with nothing outstanding.
REQ-028 SHALL, without FREE_LIST_CHECK_EN, omit the vector and the err port, with functional behaviour otherwise identical.

Structure
REQ-029 SHALL place the phys_tag_t typedef, PHYS_REGS and ARCH_REGS defaults in the shared core package used by the register map table and the instruction queue.
REQ-030 SHALL instantiate one sub-module, free_list_fifo (storage plus pointer arithmetic); grant, commit and recovery logic stay in the top.

Verification
REQ-031 SHALL check reset then 32 back-to-back alloc_req: tags 32..63 in order, then empty=1 and alloc_gnt=0 on the 33rd.
REQ-032 SHALL check empty list with free_valid(tag 40) and alloc_req in the same cycle: no grant, then tag 40 granted next cycle.
REQ-033 SHALL check 5 allocs (32..36), 2 commit_alloc, then flush: free_count returns to 30 and the next grant is tag 34.
REQ-034 SHALL check flush coinciding with commit_alloc and free_valid(tag 7): commit honoured, tag 7 queued, alloc_gnt=0 that cycle.
REQ-035 SHALL check free_valid with tag 0: ignored and free_count unchanged; with FREE_LIST_CHECK_EN, a double free of tag 45 sets err=1.
REQ-036 SHALL check wrap-around with 200 alloc/free cycles: no duplicate tag outstanding and free_count always equals the scoreboard.
